// File: rtl/digdug_vram_server_if.sv
// CPU-side byte bus into the DigDug VRAM server: REQ/ACK handshake with held address and data.
interface digdug_vram_server_if;
    logic        CPU_REQ;
    logic        CPU_WE;
    logic [10:0] CPU_AD;
    logic [7:0]  CPU_DO;
    logic [7:0]  CPU_DI;
    logic        CPU_ACK;

    // CPU bus decoder side
    modport master (
        output CPU_REQ,
        output CPU_WE,
        output CPU_AD,
        output CPU_DO,
        input  CPU_DI,
        input  CPU_ACK
    );

    // VRAM server side
    modport slave (
        input  CPU_REQ,
        input  CPU_WE,
        input  CPU_AD,
        input  CPU_DO,
        output CPU_DI,
        output CPU_ACK
    );
endinterface

// File: rtl/digdug_vram_server.sv
// DigDug VRAM server: FG tile VRAM and 3-bank sprite attribute RAM.
// Video scan reads (strobe-edge triggered) always win; CPU accesses retry until the
// addressed memory is free and finish with a one-cycle ACK.
module digdug_vram_server #(
    parameter int unsigned FG_AW    = 10,
    parameter int unsigned SP_AW    = 7,
    parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
    input  logic              CLK48M,
    input  logic              RST_N,
    input  logic              FGSCCL,
    input  logic [FG_AW-1:0]  FGSCAD,
    output logic [7:0]        FGSCDT,
    input  logic              SPATCL,
    input  logic [SP_AW-1:0]  SPATAD,
    output logic [23:0]       SPATDT,
    digdug_vram_server_if.slave cpu
);

    localparam int unsigned FgDepth = 1 << FG_AW;
    localparam int unsigned SpDepth = 1 << SP_AW;

    typedef enum logic [1:0] {CIdle, CAcc, CAck, CDone} cpu_state_e;

    logic [7:0] fg_mem [FgDepth];
    logic [7:0] sp_mem [3][SpDepth];

    logic             fg_hist_q, fg_hist_d;
    logic             fg_rd_q, fg_rd_d;
    logic [FG_AW-1:0] fg_addr_q, fg_addr_d;
    logic [7:0]       fgscdt_q, fgscdt_d;

    logic             sp_hist_q, sp_hist_d;
    logic             sp_rd_q, sp_rd_d;
    logic [SP_AW-1:0] sp_addr_q, sp_addr_d;
    logic [23:0]      spatdt_q, spatdt_d;

    cpu_state_e       state_q, state_d;
    logic [7:0]       cpu_di_q, cpu_di_d;

    logic             fg_sel, sp_sel, cpu_busy, cpu_go;
    logic [1:0]       sp_bank;
    logic [7:0]       cpu_rdata;
    logic             fg_we;
    logic [2:0]       sp_we;

    // Edge detect, address capture and registered read for both video pipelines
    always_comb begin
        fg_hist_d = FGSCCL;
        fg_rd_d   = FGSCCL & ~fg_hist_q;
        fg_addr_d = fg_rd_d ? FGSCAD : fg_addr_q;
        fgscdt_d  = fg_rd_q ? fg_mem[fg_addr_q] : fgscdt_q;

        sp_hist_d = SPATCL;
        sp_rd_d   = SPATCL & ~sp_hist_q;
        sp_addr_d = sp_rd_d ? SPATAD : sp_addr_q;
        spatdt_d  = sp_rd_q ? {sp_mem[2][sp_addr_q], sp_mem[1][sp_addr_q], sp_mem[0][sp_addr_q]}
                            : spatdt_q;
    end

    // CPU address decode; the map assumes the default 10/7-bit memory widths
    always_comb begin
        sp_bank  = cpu.CPU_AD[8:7];
        fg_sel   = ~cpu.CPU_AD[10];
        sp_sel   = cpu.CPU_AD[10] & ~cpu.CPU_AD[9] & (sp_bank != 2'd3);
        cpu_busy = (fg_sel & fg_rd_q) | (sp_sel & sp_rd_q);
        if (fg_sel) begin
            cpu_rdata = fg_mem[cpu.CPU_AD[FG_AW-1:0]];
        end else if (sp_sel) begin
            case (sp_bank)
                2'd0:    cpu_rdata = sp_mem[0][cpu.CPU_AD[SP_AW-1:0]];
                2'd1:    cpu_rdata = sp_mem[1][cpu.CPU_AD[SP_AW-1:0]];
                default: cpu_rdata = sp_mem[2][cpu.CPU_AD[SP_AW-1:0]];
            endcase
        end else begin
            cpu_rdata = OPEN_BUS;
        end
    end

    // CPU handshake FSM: next state, access strobe and read-data capture
    always_comb begin
        state_d  = state_q;
        cpu_di_d = cpu_di_q;
        cpu_go   = 1'b0;
        unique case (state_q)
            CIdle: if (cpu.CPU_REQ) state_d = CAcc;
            CAcc: begin
                // A video read on the same memory this cycle wins; retry next cycle
                if (!cpu_busy) begin
                    cpu_go  = 1'b1;
                    state_d = CAck;
                    if (!cpu.CPU_WE) cpu_di_d = cpu_rdata;
                end
            end
            CAck:  state_d = CDone;
            // Hold here until REQ drops so a held request is not serviced twice
            CDone: if (!cpu.CPU_REQ) state_d = CIdle;
            default: state_d = CIdle;
        endcase
    end

    // Write enables; unmapped writes enable nothing
    always_comb begin
        fg_we = cpu_go & cpu.CPU_WE & fg_sel;
        for (int b = 0; b < 3; b++) begin
            sp_we[b] = cpu_go & cpu.CPU_WE & sp_sel & (sp_bank == 2'(b));
        end
    end

    // State and output registers
    always_ff @(posedge CLK48M or negedge RST_N) begin
        if (!RST_N) begin
            fg_hist_q <= 1'b0;
            fg_rd_q   <= 1'b0;
            fg_addr_q <= '0;
            fgscdt_q  <= '0;
            sp_hist_q <= 1'b0;
            sp_rd_q   <= 1'b0;
            sp_addr_q <= '0;
            spatdt_q  <= '0;
            state_q   <= CIdle;
            cpu_di_q  <= '0;
        end else begin
            fg_hist_q <= fg_hist_d;
            fg_rd_q   <= fg_rd_d;
            fg_addr_q <= fg_addr_d;
            fgscdt_q  <= fgscdt_d;
            sp_hist_q <= sp_hist_d;
            sp_rd_q   <= sp_rd_d;
            sp_addr_q <= sp_addr_d;
            spatdt_q  <= spatdt_d;
            state_q   <= state_d;
            cpu_di_q  <= cpu_di_d;
        end
    end

    // RAM write ports; contents survive reset
    always_ff @(posedge CLK48M) begin
        if (fg_we) fg_mem[cpu.CPU_AD[FG_AW-1:0]] <= cpu.CPU_DO;
        for (int b = 0; b < 3; b++) begin
            if (sp_we[b]) sp_mem[b][cpu.CPU_AD[SP_AW-1:0]] <= cpu.CPU_DO;
        end
    end

    assign FGSCDT      = fgscdt_q;
    assign SPATDT      = spatdt_q;
    assign cpu.CPU_ACK = (state_q == CAck);
    assign cpu.CPU_DI  = cpu_di_q;

endmodule

// File: tb/tb_digdug_vram_server.sv
// Directed bench for digdug_vram_server: reset, FG/SP paths, contention, unmapped, reset mid-op.
module tb_digdug_vram_server;

    logic        CLK48M = 1'b0;
    logic        RST_N;
    logic        FGSCCL;
    logic [9:0]  FGSCAD;
    logic [7:0]  FGSCDT;
    logic        SPATCL;
    logic [6:0]  SPATAD;
    logic [23:0] SPATDT;

    int vectors = 0;
    int miscompares = 0;

    digdug_vram_server_if cpu_bus ();

    digdug_vram_server #(
        .FG_AW    (10),
        .SP_AW    (7),
        .OPEN_BUS (8'hFF)
    ) dut (
        .CLK48M (CLK48M),
        .RST_N  (RST_N),
        .FGSCCL (FGSCCL),
        .FGSCAD (FGSCAD),
        .FGSCDT (FGSCDT),
        .SPATCL (SPATCL),
        .SPATAD (SPATAD),
        .SPATDT (SPATDT),
        .cpu    (cpu_bus)
    );

    always #5 CLK48M = ~CLK48M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge with the FSM idle
    task automatic cpu_start(input logic we, input logic [10:0] ad, input logic [7:0] d);
        cpu_bus.CPU_REQ = 1'b1;
        cpu_bus.CPU_WE  = we;
        cpu_bus.CPU_AD  = ad;
        cpu_bus.CPU_DO  = d;
    endtask

    // Latency counts clock edges from the REQ-driving negedge to the first ACK seen
    task automatic cpu_finish(input int exp_lat, input logic chk_di, input logic [7:0] exp_di,
                              input string tag);
        int n = 0;
        while (n < 8) begin
            @(negedge CLK48M);
            n++;
            if (cpu_bus.CPU_ACK === 1'b1) break;
        end
        chk({tag, " ack"}, 32'(cpu_bus.CPU_ACK), 32'd1);
        chk({tag, " lat"}, 32'(n), 32'(exp_lat));
        if (chk_di) chk({tag, " di"}, 32'(cpu_bus.CPU_DI), 32'(exp_di));
        cpu_bus.CPU_REQ = 1'b0;
        @(negedge CLK48M);
        chk({tag, " pulse"}, 32'(cpu_bus.CPU_ACK), 32'd0);
        @(negedge CLK48M);
    endtask

    task automatic cpu_wr(input logic [10:0] ad, input logic [7:0] d, input string tag);
        cpu_start(1'b1, ad, d);
        cpu_finish(2, 1'b0, 8'h00, tag);
    endtask

    task automatic cpu_rd(input logic [10:0] ad, input logic [7:0] exp, input string tag);
        cpu_start(1'b0, ad, 8'h00);
        cpu_finish(2, 1'b1, exp, tag);
    endtask

    // Edge at cycle k; old value still visible after edge k, new value after edge k+1
    task automatic vid_fg(input logic [9:0] a, input logic [7:0] old_v, input logic [7:0] new_v,
                          input string tag);
        FGSCAD = a;
        FGSCCL = 1'b1;
        @(negedge CLK48M);
        chk({tag, " k+1"}, 32'(FGSCDT), 32'(old_v));
        @(negedge CLK48M);
        chk({tag, " k+2"}, 32'(FGSCDT), 32'(new_v));
        @(negedge CLK48M);
        FGSCCL = 1'b0;
        @(negedge CLK48M);
    endtask

    task automatic vid_sp(input logic [6:0] a, input logic [23:0] old_v, input logic [23:0] new_v,
                          input string tag);
        SPATAD = a;
        SPATCL = 1'b1;
        @(negedge CLK48M);
        chk({tag, " k+1"}, 32'(SPATDT), 32'(old_v));
        @(negedge CLK48M);
        chk({tag, " k+2"}, 32'(SPATDT), 32'(new_v));
        @(negedge CLK48M);
        SPATCL = 1'b0;
        @(negedge CLK48M);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs, asserted mid-cycle
        RST_N           = 1'b1;
        FGSCCL          = 1'($urandom);
        FGSCAD          = 10'($urandom);
        SPATCL          = 1'($urandom);
        SPATAD          = 7'($urandom);
        cpu_bus.CPU_REQ = 1'($urandom);
        cpu_bus.CPU_WE  = 1'($urandom);
        cpu_bus.CPU_AD  = 11'($urandom);
        cpu_bus.CPU_DO  = 8'($urandom);
        #12;
        RST_N = 1'b0;
        #1;
        chk("rst fgscdt", 32'(FGSCDT), 32'd0);
        chk("rst spatdt", 32'(SPATDT), 32'd0);
        chk("rst ack", 32'(cpu_bus.CPU_ACK), 32'd0);
        chk("rst di", 32'(cpu_bus.CPU_DI), 32'd0);
        repeat (3) @(negedge CLK48M);
        FGSCCL          = 1'b0;
        SPATCL          = 1'b0;
        cpu_bus.CPU_REQ = 1'b0;
        cpu_bus.CPU_WE  = 1'b0;
        @(negedge CLK48M);
        RST_N = 1'b1;
        @(negedge CLK48M);

        // Background contents used by later checks
        cpu_wr(11'h000, 8'hA1, "wr 000");
        cpu_wr(11'h400, 8'hB2, "wr 400");
        cpu_wr(11'h200, 8'h3C, "wr 200");
        cpu_wr(11'h010, 8'hC4, "wr 010");
        cpu_wr(11'h410, 8'h9E, "wr 410");

        // FG path
        cpu_wr(11'h123, 8'h5A, "wr 123");
        vid_fg(10'h123, 8'h00, 8'h5A, "fg 123");

        // Sprite path, one byte per bank
        cpu_wr(11'h405, 8'h11, "wr 405");
        cpu_wr(11'h485, 8'h22, "wr 485");
        cpu_wr(11'h505, 8'h33, "wr 505");
        vid_sp(7'h05, 24'h000000, 24'h332211, "sp 5");
        chk("fg held", 32'(FGSCDT), 32'h5A);
        cpu_rd(11'h485, 8'h22, "rd 485");

        // FG edge with CPU read of FG: one retry cycle
        FGSCAD = 10'h010;
        FGSCCL = 1'b1;
        cpu_start(1'b0, 11'h010, 8'h00);
        cpu_finish(3, 1'b1, 8'hC4, "cont fg");
        chk("cont fg data", 32'(FGSCDT), 32'hC4);
        FGSCCL = 1'b0;
        repeat (2) @(negedge CLK48M);

        // FG edge with CPU read of SP: no stall
        FGSCAD = 10'h123;
        FGSCCL = 1'b1;
        cpu_start(1'b0, 11'h410, 8'h00);
        cpu_finish(2, 1'b1, 8'h9E, "cont fg/sp");
        chk("cont fg/sp data", 32'(FGSCDT), 32'h5A);
        FGSCCL = 1'b0;
        repeat (2) @(negedge CLK48M);

        // SP edge with CPU read of SP: one retry cycle
        SPATAD = 7'h05;
        SPATCL = 1'b1;
        cpu_start(1'b0, 11'h405, 8'h00);
        cpu_finish(3, 1'b1, 8'h11, "cont sp");
        chk("cont sp data", 32'(SPATDT), 32'h332211);
        SPATCL = 1'b0;
        repeat (2) @(negedge CLK48M);

        // Unmapped read and write
        cpu_rd(11'h600, 8'hFF, "rd 600");
        cpu_wr(11'h600, 8'h5A, "wr 600");
        cpu_rd(11'h000, 8'hA1, "rb 000");
        cpu_rd(11'h200, 8'h3C, "rb 200");
        cpu_rd(11'h400, 8'hB2, "rb 400");

        // Reset while the write of 0x77 to 0x200 sits in C_ACC
        cpu_start(1'b1, 11'h200, 8'h77);
        @(negedge CLK48M);
        RST_N = 1'b0;
        #1;
        chk("mid rst ack", 32'(cpu_bus.CPU_ACK), 32'd0);
        chk("mid rst di", 32'(cpu_bus.CPU_DI), 32'd0);
        chk("mid rst fgscdt", 32'(FGSCDT), 32'd0);
        chk("mid rst spatdt", 32'(SPATDT), 32'd0);
        @(negedge CLK48M);
        chk("in rst ack a", 32'(cpu_bus.CPU_ACK), 32'd0);
        @(negedge CLK48M);
        chk("in rst ack b", 32'(cpu_bus.CPU_ACK), 32'd0);
        // Release with REQ held; a same-edge FG read of 0x200 shows the pre-write value
        // and pushes the restarted write back one cycle
        FGSCAD = 10'h200;
        FGSCCL = 1'b1;
        RST_N  = 1'b1;
        cpu_finish(3, 1'b0, 8'h00, "restart wr");
        chk("mid rst unchanged", 32'(FGSCDT), 32'h3C);
        FGSCCL = 1'b0;
        repeat (2) @(negedge CLK48M);
        vid_fg(10'h200, 8'h3C, 8'h77, "fg 200");
        cpu_rd(11'h200, 8'h77, "rd 200");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
